// File: rtl/fir_tap_loader.sv
// fir_tap_loader: streams N coefficients into the FIR tap RAM (bram11 port).
// Define TAP_VERIFY_EN to add a readback checksum pass that drives err.
module fir_tap_loader #(
  parameter int N     = 11,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] s_tdata,
  input  logic             s_tvalid,
  output logic             s_tready,
  output logic             tap_en,
  output logic [3:0]       tap_we,
  output logic [11:0]      tap_a,
  output logic [31:0]      tap_di,
  input  logic [31:0]      tap_do,
  output logic             busy,
  output logic             done,
  output logic             err
);

`ifdef TAP_VERIFY_EN
  typedef enum logic [2:0] {
    IDLE, WRITE, VERIFY_RD, VERIFY_CHK, DONE
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, WRITE, DONE
  } state_t;
`endif

  state_t state_q, state_d;
  logic [11:0] idx_q, idx_d;
  logic [11:0] tap_a_q, tap_a_d;
  logic [31:0] tap_di_q, tap_di_d;
  logic [3:0]  tap_we_q, tap_we_d;
  logic        tap_en_q, tap_en_d;
  logic signed [WIDTH-1:0] coef;
  logic [31:0] coef_x;
  logic        hs;
  logic        last;

  assign coef   = s_tdata;
  assign coef_x = 32'(coef);
  assign hs     = s_tvalid & s_tready;
  assign last   = idx_q == 12'(N - 1);

  assign s_tready = state_q == WRITE;
  assign busy     = state_q != IDLE;
  assign done     = state_q == DONE;
  assign tap_en   = tap_en_q;
  assign tap_we   = tap_we_q;
  assign tap_a    = tap_a_q;
  assign tap_di   = tap_di_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tap_en_d = 1'b0;
    tap_we_d = 4'h0;
    tap_a_d  = tap_a_q;
    tap_di_d = tap_di_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WRITE;
          idx_d   = '0;
        end
      end
      WRITE: begin
        if (hs) begin
          tap_en_d = 1'b1;
          tap_we_d = 4'hF;
          tap_a_d  = idx_q;
          tap_di_d = coef_x;
          idx_d    = idx_q + 12'd1;
          if (last) begin
            idx_d   = '0;
`ifdef TAP_VERIFY_EN
            state_d = VERIFY_RD;
`else
            state_d = DONE;
`endif
          end
        end
      end
`ifdef TAP_VERIFY_EN
      VERIFY_RD: begin
        tap_en_d = 1'b1;
        tap_a_d  = idx_q;
        idx_d    = idx_q + 12'd1;
        if (last) begin
          idx_d   = '0;
          state_d = VERIFY_CHK;
        end
      end
      VERIFY_CHK: state_d = DONE;
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      tap_en_q <= 1'b0;
      tap_we_q <= 4'h0;
      tap_a_q  <= '0;
      tap_di_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      tap_en_q <= tap_en_d;
      tap_we_q <= tap_we_d;
      tap_a_q  <= tap_a_d;
      tap_di_q <= tap_di_d;
    end
  end

`ifdef TAP_VERIFY_EN
  logic [31:0] sum_w_q, sum_w_d;
  logic [31:0] sum_r_q, sum_r_d;
  logic [31:0] sum_r_nx;
  logic        dval_q, err_q, err_d, mism;

  // Reads leave the port registered, so the last word lands in DONE.
  assign sum_r_nx = dval_q ? sum_r_q + tap_do : sum_r_q;
  assign mism     = sum_r_nx != sum_w_q;
  assign err      = (state_q == DONE) ? mism : err_q;

  always_comb begin
    sum_w_d = sum_w_q;
    sum_r_d = sum_r_nx;
    err_d   = err_q;
    if (state_q == IDLE && start) begin
      sum_w_d = '0;
      sum_r_d = '0;
      err_d   = 1'b0;
    end
    if (hs) sum_w_d = sum_w_q + coef_x;
    if (state_q == DONE) err_d = mism;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_w_q <= '0;
      sum_r_q <= '0;
      dval_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sum_w_q <= sum_w_d;
      sum_r_q <= sum_r_d;
      dval_q  <= tap_en_q & ~|tap_we_q;
      err_q   <= err_d;
    end
  end
`else
  logic unused_do;
  assign unused_do = ^tap_do;
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_fir_tap_loader.sv
// tb_fir_tap_loader: directed bench for fir_tap_loader with a bram11 model.
// Expected cycle counts follow TAP_VERIFY_EN when it is defined.
module tb_fir_tap_loader;
  localparam int N = 11;

`ifdef TAP_VERIFY_EN
  localparam int DONE_HELD = 24;
  localparam int DONE_TOG  = 34;
  localparam int W_DONE    = 4;
`else
  localparam int DONE_HELD = 12;
  localparam int DONE_TOG  = 22;
  localparam int W_DONE    = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] s_tdata;
  logic        s_tvalid, s_tready;
  logic        tap_en;
  logic [3:0]  tap_we;
  logic [11:0] tap_a;
  logic [31:0] tap_di, tap_do;
  logic        busy, done, err;

  logic        w_start;
  logic [15:0] w_tdata;
  logic        w_tvalid, w_tready;
  logic        w_en;
  logic [3:0]  w_we;
  logic [11:0] w_a;
  logic [31:0] w_di, w_do;
  logic        w_busy, w_done, w_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fir_tap_loader #(.N(N), .WIDTH(32)) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .tap_en(tap_en), .tap_we(tap_we), .tap_a(tap_a),
    .tap_di(tap_di), .tap_do(tap_do),
    .busy(busy), .done(done), .err(err)
  );

  fir_tap_loader #(.N(1), .WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .start(w_start),
    .s_tdata(w_tdata), .s_tvalid(w_tvalid), .s_tready(w_tready),
    .tap_en(w_en), .tap_we(w_we), .tap_a(w_a),
    .tap_di(w_di), .tap_do(w_do),
    .busy(w_busy), .done(w_done), .err(w_err)
  );

  // bram11 model: synchronous read, byte-enabled write (full words here)
  logic [31:0] ram [0:15];
  logic [31:0] ram_do;
  logic [11:0] wr_log [0:63];
  int          wr_cnt = 0;
  logic [31:0] w_mem;

  always @(posedge clk) begin
    if (tap_en) begin
      ram_do <= ram[tap_a[3:0]];
      if (tap_we == 4'hF) begin
        ram[tap_a[3:0]]        <= tap_di;
        wr_log[wr_cnt[5:0]]    <= tap_a;
        wr_cnt                 <= wr_cnt + 1;
      end
    end
    if (w_en) begin
      w_do <= w_mem;
      if (w_we == 4'hF) w_mem <= w_di;
    end
  end

`ifdef TAP_VERIFY_EN
  logic        corrupt = 1'b0;
  logic [11:0] rd_a_q;
  always @(posedge clk) if (tap_en) rd_a_q <= tap_a;
  assign tap_do = (corrupt && rd_a_q == 12'd5) ? ram_do ^ 32'h1 : ram_do;
`else
  assign tap_do = ram_do ^ 32'hDEAD_BEEF;
`endif

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Pulse start, stream N words base+1..base+N; report done cycle (cycle 1
  // follows the start edge), busy-low count in 1..N and err in done cycle.
  task automatic run_load(input bit toggle, input int base,
                          output int dcyc, output int blo,
                          output logic derr);
    int sent;
    bit hs;
    sent = 0; dcyc = -1; blo = 0; derr = 1'b0;
    @(negedge clk);
    start = 1'b1; s_tvalid = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 60 && dcyc < 0; c++) begin
      if (c <= N && !busy) blo++;
      if (done) begin dcyc = c; derr = err; end
      s_tvalid = sent < N && !(toggle && c % 2 == 0);
      s_tdata  = 32'(base + sent + 1);
      hs = s_tvalid && s_tready;
      @(posedge clk);
      #1;
      if (hs) sent++;
    end
    s_tvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int dc, bl, base_w, wd;
    logic de;
    rst = 1'b0; start = 1'b0; s_tvalid = 1'b0; s_tdata = '0;
    w_start = 1'b0; w_tvalid = 1'b0; w_tdata = '0;
    #2;
    check("rst_ctl", {s_tready, tap_en, tap_we, busy, done, err}, 32'h0);
    check("rst_a", 32'(tap_a), 32'h0);
    check("rst_di", tap_di, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // mid-WRITE start is ignored, then async reset clears everything
    @(negedge clk);
    start = 1'b1; s_tvalid = 1'b1; s_tdata = 32'd100;
    @(posedge clk);
    #1;
    for (int c = 1; c <= 5; c++) begin
      start = (c == 3);
      s_tdata = 32'(99 + c);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    check("restart_a", 32'(tap_a), 32'd4);
    check("restart_di", tap_di, 32'd104);
    check("restart_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("midrst_ctl", {s_tready, tap_en, tap_we, busy, done, err}, 32'h0);
    check("midrst_a", 32'(tap_a), 32'h0);
    check("midrst_di", tap_di, 32'h0);
    s_tvalid = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // held valid: coefficients 1..11
    base_w = wr_cnt;
    run_load(1'b0, 0, dc, bl, de);
    check("held_done_cyc", 32'(dc), 32'(DONE_HELD));
    check("held_busy_lo", 32'(bl), 32'd0);
    check("held_err", 32'(de), 32'd0);
    check("held_idle_busy", 32'(busy), 32'd0);
    check("held_idle_en", 32'(tap_en), 32'd0);
    @(posedge clk); #1;
    check("held_nwr", 32'(wr_cnt - base_w), 32'd11);
    for (int i = 0; i < N; i++) check("held_ram", ram[i], 32'(i + 1));

    // valid toggling: words 101..111 accepted on odd edges only
    base_w = wr_cnt;
    run_load(1'b1, 100, dc, bl, de);
    check("tog_done_cyc", 32'(dc), 32'(DONE_TOG));
    check("tog_err", 32'(de), 32'd0);
    @(posedge clk); #1;
    check("tog_nwr", 32'(wr_cnt - base_w), 32'd11);
    for (int i = 0; i < N; i++) begin
      check("tog_order", 32'(wr_log[base_w + i]), 32'(i));
      check("tog_ram", ram[i], 32'(101 + i));
    end
    check("tog_err_hold", 32'(err), 32'd0);

`ifdef TAP_VERIFY_EN
    // readback of address 5 corrupted: err set in done cycle and sticky
    corrupt = 1'b1;
    run_load(1'b0, 0, dc, bl, de);
    check("bad_done_cyc", 32'(dc), 32'd24);
    check("bad_err_done", 32'(de), 32'd1);
    corrupt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("bad_err_hold", 32'(err), 32'd1);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("bad_err_clr", 32'(err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
`endif

    // WIDTH=16, N=1: sign extension and single-handshake load
    wd = -1;
    @(negedge clk);
    w_start = 1'b1; w_tvalid = 1'b1; w_tdata = 16'h8001;
    @(posedge clk);
    #1 w_start = 1'b0;
    check("w16_ready", 32'(w_tready), 32'd1);
    check("w16_busy", 32'(w_busy), 32'd1);
    for (int c = 1; c <= 8; c++) begin
      if (w_done && wd < 0) wd = c;
      if (c == 2) begin
        w_tvalid = 1'b0;
        check("w16_di", w_di, 32'hFFFF_8001);
        check("w16_a", 32'(w_a), 32'd0);
        check("w16_we", 32'({w_en, w_we}), 32'h1F);
      end
      @(posedge clk);
      #1;
    end
    check("w16_done_cyc", 32'(wd), 32'(W_DONE));
    check("w16_err", 32'(w_err), 32'd0);
    check("w16_ram", w_mem, 32'hFFFF_8001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
